// File: rtl/mdu.sv
// mdu: multiply/divide unit for the MIPS datapath. Owns HI/LO.
//
// Ports:
//   clk    - system clock, all state updates on posedge
//   reset  - synchronous, active-high; aborts any operation in flight
//   start  - one-cycle request strobe qualifying op
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A, B   - operands from GRF read ports rs / rt
//   busy   - high while a mult/div is in flight (registered)
//   HI, LO - architectural HI/LO registers
//
// The full 64-bit result is computed at the accepting edge and parked in a
// temp register. A countdown then holds busy high for MULT_CYCLES or
// DIV_CYCLES cycles before the temp value is committed to HI/LO.
module mdu #(
  parameter int MULT_CYCLES = 5,   // 1..15
  parameter int DIV_CYCLES  = 10   // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {sIdle, sBusy} state_t;

  // Pending result; commit=0 marks a divide by zero that must leave HI/LO alone.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        commit;
  } result_t;

  state_t      state, stateNext;
  logic [3:0]  count, countNext;
  logic [31:0] hiReg, hiNext;
  logic [31:0] loReg, loNext;
  result_t     temp, tempNext;
  result_t     opResult;

  logic [63:0] prodS, prodU;
  logic [31:0] divisor;
  logic        divOvf;
  logic [31:0] quoS, remS;

  // ---------------------------------------------------------------------------
  // Arithmetic on the current operands
  // ---------------------------------------------------------------------------
  always_comb begin
    // Low 64 bits of a 64x64 product of sign-extended operands is the signed product.
    prodS = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prodU = {32'b0, A} * {32'b0, B};

    // A zero divisor (result discarded anyway) and MIN/-1 (quotient overflows)
    // both divide by 1 instead: the latter then yields exactly LO=MIN, HI=0.
    divOvf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    divisor = ((B == 32'd0) || divOvf) ? 32'd1 : B;

    quoS = 32'($signed(A) / $signed(divisor));
    remS = 32'($signed(A) % $signed(divisor));

    opResult = '0;
    case (op)
      OP_MULT:  opResult = '{hi: prodS[63:32], lo: prodS[31:0], commit: 1'b1};
      OP_MULTU: opResult = '{hi: prodU[63:32], lo: prodU[31:0], commit: 1'b1};
      OP_DIV:   opResult = '{hi: remS, lo: quoS, commit: (B != 32'd0)};
      OP_DIVU:  opResult = '{hi: A % divisor, lo: A / divisor, commit: (B != 32'd0)};
      default:  opResult = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control: next-state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    countNext = count;
    hiNext    = hiReg;
    loNext    = loReg;
    tempNext  = temp;

    case (state)
      sIdle: begin
        if (start) begin
          case (op)
            OP_MTHI: hiNext = A;
            OP_MTLO: loNext = A;
            OP_MULT, OP_MULTU: begin
              tempNext  = opResult;
              countNext = MULT_N;
              stateNext = sBusy;
            end
            OP_DIV, OP_DIVU: begin
              tempNext  = opResult;
              countNext = DIV_N;
              stateNext = sBusy;
            end
            default: ;
          endcase
        end
      end
      sBusy: begin
        // start is deliberately ignored here: no queueing while busy.
        if (count == 4'd1) begin
          if (temp.commit) begin
            hiNext = temp.hi;
            loNext = temp.lo;
          end
          countNext = 4'd0;
          stateNext = sIdle;
        end else begin
          countNext = count - 4'd1;
        end
      end
      default: stateNext = sIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= sIdle;
      count <= 4'd0;
      hiReg <= 32'd0;
      loReg <= 32'd0;
      temp  <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
      hiReg <= hiNext;
      loReg <= loNext;
      temp  <= tempNext;
    end
  end

  assign busy = (state == sBusy);
  assign HI   = hiReg;
  assign LO   = loReg;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized traffic.
// The stimulus side advances a timestamp-based reference model and queues the
// expected HI/LO/busy for each cycle; a monitor compares at the falling edge.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        bsy;
    string       name;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  // Reference model: architectural HI/LO plus one pending result that lands
  // at absolute cycle mDone. Busy is simply "a result is pending".
  logic [31:0] mHi = 0, mLo = 0, rHi = 0, rLo = 0;
  bit          mPend = 0, rOk = 0;
  int          mDone = 0;

  function automatic void refOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit ok);
    longint sa, sd, q, r, p;
    longint unsigned ua, ub, up;
    ok = 1; h = 0; l = 0;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sd; h = p[63:32]; l = p[31:0]; end
      3'd1: begin ua = a; ub = b; up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd2: begin
        if (b == 0) ok = 0;
        else begin
          // magnitude divide, then apply sign: truncation toward zero
          q = (sa < 0 ? -sa : sa) / (sd < 0 ? -sd : sd);
          if ((sa < 0) != (sd < 0)) q = -q;
          r = sa - q * sd;
          l = q[31:0]; h = r[31:0];
        end
      end
      3'd3: begin
        if (b == 0) ok = 0;
        else begin l = a / b; h = a % b; end
      end
      default: ok = 0;
    endcase
  endfunction

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l, input logic bs);
    exp_t e;
    e.cyc = cyc; e.hi = h; e.lo = l; e.bsy = bs; e.name = nm;
    expq.push_back(e);
  endtask

  task automatic step(input bit rst, input bit st, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset = rst; start = st; op = o; A = a; B = b;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mHi = 0; mLo = 0; mPend = 0;
    end else if (mPend) begin
      if (cyc == mDone) begin
        if (rOk) begin mHi = rHi; mLo = rLo; end
        mPend = 0;
      end
    end else if (st) begin
      case (o)
        3'd4: mHi = a;
        3'd5: mLo = a;
        3'd0, 3'd1, 3'd2, 3'd3: begin
          refOp(o, a, b, rHi, rLo, rOk);
          mPend = 1;
          mDone = cyc + ((o < 3'd2) ? MC : DC);
        end
        default: ;
      endcase
    end
    push("model", mHi, mLo, mPend);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    step(0, 1, o, a, b);
  endtask

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s.%s cyc=%0d got=%h want=%h", nm, fld, cyc, got, want);
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      exp_t e;
      e = expq.pop_front();
      chk(e.name, "HI", HI, e.hi);
      chk(e.name, "LO", LO, e.lo);
      chk(e.name, "busy", {31'd0, busy}, {31'd0, e.bsy});
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    step(1, 0, 3'd0, 32'd0, 32'd0);
    step(1, 1, 3'd0, 32'd5, 32'd5);
    push("reset", 32'd0, 32'd0, 1'b0);

    // MTHI / MTLO
    issue(3'd4, 32'h1234_5678, 32'd0);
    push("mthi", 32'h1234_5678, 32'd0, 1'b0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    push("mtlo", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    // signed and unsigned multiply
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    push("mult_hold", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    idle(MC);
    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    idle(MC);
    push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);

    // divides
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    idle(DC);
    push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(3'd3, 32'd7, 32'd2);
    idle(DC);
    push("divu", 32'd1, 32'd3, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DC);
    push("div_ovf", 32'd0, 32'h8000_0000, 1'b0);

    // divide by zero keeps HI/LO
    issue(3'd4, 32'hAAAA_0000, 32'd0);
    issue(3'd5, 32'h0000_BBBB, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    idle(DC - 1);
    push("div0_busy", 32'hAAAA_0000, 32'h0000_BBBB, 1'b1);
    idle(1);
    push("div0", 32'hAAAA_0000, 32'h0000_BBBB, 1'b0);

    // start while busy is ignored
    issue(3'd0, 32'd3, 32'd4);
    idle(1);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(3'd2, 32'd9, 32'd3);
    idle(1);
    push("busy_ign_hold", 32'hAAAA_0000, 32'h0000_BBBB, 1'b1);
    idle(1);
    push("busy_ign", 32'd0, 32'd12, 1'b0);

    // reset mid-operation
    issue(3'd2, 32'd100, 32'd7);
    idle(3);
    step(1, 0, 3'd0, 32'd0, 32'd0);
    push("rst_mid", 32'd0, 32'd0, 1'b0);
    idle(12);
    push("rst_nocommit", 32'd0, 32'd0, 1'b0);
    issue(3'd0, 32'd2, 32'd2);
    idle(MC);
    push("post_rst_mult", 32'd0, 32'd4, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = pick();
      b = ($urandom_range(7) == 0) ? 32'd0 : pick();
      step(($urandom_range(99) == 0), $urandom_range(1) == 1, 3'($urandom_range(7)), a, b);
    end
    idle(DC + 1);

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passes++;
    else $display("FAIL drain remaining=%0d want=0", expq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
